axis_frame_loopback: RTL

Parametrised AXI4-Stream frame loopback in the 156.25 MHz MAC-side domain, successor to the DPI socket loopback used in compliance benches. Accepted TX beats are stored in an internal synthesizable FIFO and replayed on the RX interface. The FIFO runs in cut-through or store-and-forward mode. Store-and-forward drops a frame only when that frame cannot fit. Runtime enable selects loopback or sink, and the block exports frame statistics. No DPI and no simulation-only constructs.

---
 rtl/axis_frame_loopback_if.sv | 19 +
 rtl/axis_frame_loopback.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/axis_frame_loopback_if.sv
// ---------------------------------------------------------------------------
// axis_frame_loopback_if
//   AXI4-Stream bundle used on both sides of the frame loopback.
//   master : drives tdata/tkeep/tvalid/tlast, samples tready
//   slave  : samples tdata/tkeep/tvalid/tlast, drives tready
// ---------------------------------------------------------------------------
interface axis_frame_loopback_if #(
    parameter int DATA_W = 64,
    parameter int KEEP_W = DATA_W / 8
);
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_frame_loopback.sv
// ---------------------------------------------------------------------------
// axis_frame_loopback
//   Stores accepted TX beats in a FIFO and replays them on RX. Cut-through
//   (STORE_FWD=0) exposes each beat the cycle after it is written;
//   store-and-forward (STORE_FWD=1) exposes a frame only once its tlast beat
//   is written, and drops a frame that cannot fit in an otherwise empty FIFO.
//   lb_en, sampled on the first beat of each frame, selects loopback or sink.
//
// Ports
//   clk156              sole clock
//   reset               synchronous, active-high
//   lb_en               1 = loop back, 0 = accept and discard
//   tx_axis (slave)     ingress stream
//   rx_axis (master)    egress stream
//   fill_level          beats written and not yet read (incl. uncommitted)
//   stat_frames_in      accepted tlast beats (looped, sunk or dropped)
//   stat_frames_out     tlast handshakes on rx_axis
//   stat_frames_dropped frames sunk or dropped
// ---------------------------------------------------------------------------
module axis_frame_loopback #(
    parameter int DATA_W    = 64,
    parameter int KEEP_W    = DATA_W / 8,
    parameter int DEPTH     = 64,
    parameter bit STORE_FWD = 1'b1
) (
    input  logic                     clk156,
    input  logic                     reset,
    input  logic                     lb_en,
    axis_frame_loopback_if.slave     tx_axis,
    axis_frame_loopback_if.master    rx_axis,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic [31:0]              stat_frames_in,
    output logic [31:0]              stat_frames_out,
    output logic [31:0]              stat_frames_dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int MW = DATA_W + KEEP_W + 1;

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_SINK,
        ST_DROP
    } wr_state_e;

    wr_state_e       r_state;
    wr_state_e       w_state_nxt;
    logic            r_first;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_wr_commit;
    logic [PW-1:0]   r_rd_ptr;
    logic [31:0]     r_stat_in;
    logic [31:0]     r_stat_out;
    logic [31:0]     r_stat_drop;
    logic [MW-1:0]   r_mem [DEPTH];

    logic [PW-1:0]   w_fill;
    logic            w_full;
    logic            w_sf_escape;
    logic            w_tx_ready;
    logic            w_tx_hs;
    logic            w_rx_valid;
    logic            w_rx_hs;
    logic            w_mem_we;
    logic            w_rewind;
    logic            w_drop_done;
    logic [MW-1:0]   w_rd_word;

    assign w_fill      = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_fill == PW'(DEPTH));
    // A full FIFO holding only the frame still being written can never drain,
    // so the frame is larger than the FIFO: accept the next beat and drop it.
    assign w_sf_escape = STORE_FWD && (r_wr_commit == r_rd_ptr);

    always_ff @(posedge clk156) begin
        if (reset) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case statement leaves a signal unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_tx_ready  = 1'b1;
        w_mem_we    = 1'b0;
        w_rewind    = 1'b0;
        w_drop_done = 1'b0;
        case (r_state)
            ST_NORMAL: begin
                if (r_first && !lb_en) begin
                    // First beat of a sunk frame: discard from the start.
                    if (tx_axis.tvalid) begin
                        if (tx_axis.tlast) w_drop_done = 1'b1;
                        else               w_state_nxt = ST_SINK;
                    end
                end else if (w_full) begin
                    w_tx_ready = w_sf_escape;
                    if (tx_axis.tvalid && w_sf_escape) begin
                        w_rewind = 1'b1;
                        if (tx_axis.tlast) w_drop_done = 1'b1;
                        else               w_state_nxt = ST_DROP;
                    end
                end else begin
                    w_mem_we = tx_axis.tvalid;
                end
            end
            ST_SINK, ST_DROP: begin
                if (tx_axis.tvalid && tx_axis.tlast) begin
                    w_drop_done = 1'b1;
                    w_state_nxt = ST_NORMAL;
                end
            end
            default: w_state_nxt = ST_NORMAL;
        endcase
    end

    assign w_tx_hs    = tx_axis.tvalid && w_tx_ready;
    assign w_rx_valid = (r_rd_ptr != r_wr_commit);
    assign w_rx_hs    = w_rx_valid && rx_axis.tready;

    // NOTE: sequential state uses non-blocking assignments so every register
    // in this block samples the pre-edge values of its neighbours.
    always_ff @(posedge clk156) begin
        if (reset) begin
            r_first     <= 1'b1;
            r_wr_ptr    <= '0;
            r_wr_commit <= '0;
            r_rd_ptr    <= '0;
            r_stat_in   <= '0;
            r_stat_out  <= '0;
            r_stat_drop <= '0;
        end else begin
            if (w_tx_hs) begin
                r_first <= tx_axis.tlast;
                if (tx_axis.tlast) r_stat_in <= r_stat_in + 32'd1;
            end
            if (w_mem_we) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
                if (!STORE_FWD || tx_axis.tlast) r_wr_commit <= r_wr_ptr + PW'(1);
            end else if (w_rewind) begin
                r_wr_ptr <= r_wr_commit;
            end
            if (w_drop_done) r_stat_drop <= r_stat_drop + 32'd1;
            if (w_rx_hs) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                if (rx_axis.tlast) r_stat_out <= r_stat_out + 32'd1;
            end
        end
    end

    // NOTE: the storage array has no reset; validity is carried entirely by
    // the pointers, and the RX outputs are gated to zero while not valid.
    always_ff @(posedge clk156) begin
        if (w_mem_we) begin
            r_mem[r_wr_ptr[AW-1:0]] <= {tx_axis.tlast, tx_axis.tkeep, tx_axis.tdata};
        end
    end

    assign w_rd_word = r_mem[r_rd_ptr[AW-1:0]];

    assign tx_axis.tready      = w_tx_ready;
    assign rx_axis.tvalid      = w_rx_valid;
    assign rx_axis.tdata       = w_rx_valid ? w_rd_word[DATA_W-1:0]               : '0;
    assign rx_axis.tkeep       = w_rx_valid ? w_rd_word[DATA_W +: KEEP_W]         : '0;
    assign rx_axis.tlast       = w_rx_valid ? w_rd_word[MW-1]                     : 1'b0;
    assign fill_level          = w_fill;
    assign stat_frames_in      = r_stat_in;
    assign stat_frames_out     = r_stat_out;
    assign stat_frames_dropped = r_stat_drop;
endmodule
